// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and result packing.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_ON     = 2'b01,
        DIV_END    = 2'b10,
        DIV_BYZERO = 2'b11
    } div_state_e;

    localparam int unsigned DIV_MAX_W = 64;

    // {remainder, quotient}; callers zero-extend to DIV_MAX_W and truncate to 2*width.
    function automatic logic [2*DIV_MAX_W-1:0] pack_result(
        input logic [DIV_MAX_W-1:0] rem,
        input logic [DIV_MAX_W-1:0] quo,
        input int unsigned          width
    );
        return ((2*DIV_MAX_W)'(rem) << width) | (2*DIV_MAX_W)'(quo);
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in the dividend MSB, subtract the divisor if it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_c,
    output logic             o_qbit_c
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;
    logic [WIDTH:0] w_sel;
    logic           w_ge;

    always_comb begin
        w_trial  = {i_rem, i_msb};
        w_ge     = (w_trial >= {1'b0, i_divisor});
        w_diff   = w_trial - {1'b0, i_divisor};
        w_sel    = w_ge ? w_diff : w_trial;
        // partial remainder stays below the divisor, so the top bit is always zero
        o_rem_c  = WIDTH'(w_sel);
        o_qbit_c = w_ge;
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider with start/annul/ready handshake; WIDTH+1 cycles per divide.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned RES_W = 2 * WIDTH;

    div_state_e         r_state,    w_state_nxt;
    logic [WIDTH-1:0]   r_dividend, w_dividend_nxt;
    logic [WIDTH-1:0]   r_divisor,  w_divisor_nxt;
    logic [WIDTH-1:0]   r_rem,      w_rem_nxt;
    logic [WIDTH-1:0]   r_quo,      w_quo_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic               r_signed,   w_signed_nxt;
    logic               r_neg_a,    w_neg_a_nxt;
    logic               r_neg_b,    w_neg_b_nxt;
    logic [RES_W-1:0]   r_result,   w_result_nxt;
    logic               r_ready,    w_ready_nxt;

    logic [WIDTH-1:0]   w_step_rem;
    logic               w_step_qbit;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_quo_fin;
    logic [WIDTH-1:0]   w_rem_fin;
    logic [RES_W-1:0]   w_packed;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_msb     (r_dividend[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem_c   (w_step_rem),
        .o_qbit_c  (w_step_qbit)
    );

    // Operand magnitudes at acceptance and sign fix-up at finalize
    always_comb begin
        w_abs_a   = (signed_div_i && opdata1_i[WIDTH-1]) ? WIDTH'(WIDTH'(0) - opdata1_i) : opdata1_i;
        w_abs_b   = (signed_div_i && opdata2_i[WIDTH-1]) ? WIDTH'(WIDTH'(0) - opdata2_i) : opdata2_i;
        w_quo_fin = (r_signed && (r_neg_a ^ r_neg_b)) ? WIDTH'(WIDTH'(0) - r_quo) : r_quo;
        w_rem_fin = (r_signed && r_neg_a) ? WIDTH'(WIDTH'(0) - r_rem) : r_rem;
        w_packed  = RES_W'(pack_result(DIV_MAX_W'(w_rem_fin), DIV_MAX_W'(w_quo_fin), WIDTH));
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_rem_nxt      = r_rem;
        w_quo_nxt      = r_quo;
        w_cnt_nxt      = r_cnt;
        w_signed_nxt   = r_signed;
        w_neg_a_nxt    = r_neg_a;
        w_neg_b_nxt    = r_neg_b;
        w_result_nxt   = '0;
        w_ready_nxt    = 1'b0;

        case (r_state)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_nxt = DIV_BYZERO;
                    end else begin
                        w_state_nxt    = DIV_ON;
                        w_signed_nxt   = signed_div_i;
                        w_neg_a_nxt    = opdata1_i[WIDTH-1];
                        w_neg_b_nxt    = opdata2_i[WIDTH-1];
                        w_dividend_nxt = w_abs_a;
                        w_divisor_nxt  = w_abs_b;
                        w_rem_nxt      = '0;
                        w_quo_nxt      = '0;
                        w_cnt_nxt      = '0;
                    end
                end
            end
            DIV_BYZERO: begin
                w_state_nxt = annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    w_state_nxt = DIV_FREE;
                end else if (r_cnt == CNT_W'(WIDTH)) begin
                    w_state_nxt  = DIV_END;
                    w_result_nxt = w_packed;
                    w_ready_nxt  = 1'b1;
                end else begin
                    w_rem_nxt      = w_step_rem;
                    w_quo_nxt      = {r_quo[WIDTH-2:0], w_step_qbit};
                    w_dividend_nxt = {r_dividend[WIDTH-2:0], 1'b0};
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                end
            end
            DIV_END: begin
                // divide-by-zero arrives here with ready low; it rises on the following edge
                if (start_i) begin
                    w_result_nxt = r_result;
                    w_ready_nxt  = 1'b1;
                end else begin
                    w_state_nxt = DIV_FREE;
                end
            end
            default: begin
                w_state_nxt = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_FREE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_signed   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_rem      <= w_rem_nxt;
            r_quo      <= w_quo_nxt;
            r_cnt      <= w_cnt_nxt;
            r_signed   <= w_signed_nxt;
            r_neg_a    <= w_neg_a_nxt;
            r_neg_b    <= w_neg_b_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_iter.sv
// Directed and model-checked bench for div_iter at WIDTH=32 and WIDTH=8.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sg32, st32, an32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32;
    logic        sg8, st8, an8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .signed_div_i(sg32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32)
    );

    div_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .signed_div_i(sg8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic avoids the most-negative / -1 overflow
    function automatic logic [63:0] ref_div32(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input string tag, input bit w8, input bit sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input bit scramble);
        int          n;
        int          lat;
        logic [63:0] exp_res;
        logic [63:0] res;
        logic        rdy;
        lat     = w8 ? ((b[7:0] == 8'd0) ? 2 : 9) : ((b == 32'd0) ? 2 : 33);
        exp_res = w8 ? {48'b0, er[7:0], eq[7:0]} : {er, eq};
        @(negedge clk);
        if (w8) begin sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; end
        else    begin sg32 = sg; a32 = a; b32 = b; st32 = 1'b1; end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            rdy = w8 ? rdy8 : rdy32;
            res = w8 ? {48'b0, res8} : res32;
            if (n == 1 && scramble) begin
                a32 = ~a32; b32 = 32'h3; sg32 = ~sg32;
                a8  = ~a8;  b8  = 8'h3;  sg8  = ~sg8;
            end
            if (n == 2) chk({tag, " busy result"}, res, 64'd0);
        end while (!rdy && n < 100);
        chk({tag, " latency"}, 64'(n - 1), 64'(lat));
        chk({tag, " result"}, res, exp_res);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " hold ready"}, 64'(w8 ? rdy8 : rdy32), 64'd1);
        chk({tag, " hold result"}, w8 ? {48'b0, res8} : res32, exp_res);
        @(negedge clk);
        if (w8) st8 = 1'b0; else st32 = 1'b0;
        @(posedge clk); #1;
        chk({tag, " drop ready"}, 64'(w8 ? rdy8 : rdy32), 64'd0);
        chk({tag, " drop result"}, w8 ? {48'b0, res8} : res32, 64'd0);
    endtask

    // Abort an ON operation after ab_cyc steps, via annul (use_rst=0) or rst (use_rst=1)
    task automatic run_abort(input string tag, input int ab_cyc, input bit use_rst);
        bit seen;
        @(negedge clk);
        sg32 = 1'b0; a32 = 32'd100; b32 = 32'd3; st32 = 1'b1;
        @(posedge clk);
        repeat (ab_cyc) @(posedge clk);
        @(negedge clk);
        if (use_rst) rst = 1'b1; else an32 = 1'b1;
        st32 = 1'b0;
        @(posedge clk); #1;
        chk({tag, " ready"}, 64'(rdy32), 64'd0);
        chk({tag, " result"}, res32, 64'd0);
        @(negedge clk);
        rst = 1'b0; an32 = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rdy32) seen = 1'b1;
        end
        chk({tag, " no ready"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] rexp;
        bit          rsg;
        rst = 1'b1;
        sg32 = 1'b0; st32 = 1'b0; an32 = 1'b0; a32 = '0; b32 = '0;
        sg8  = 1'b0; st8  = 1'b0; an8  = 1'b0; a8  = '0; b8  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready32", 64'(rdy32), 64'd0);
        chk("reset result32", res32, 64'd0);
        chk("reset ready8", 64'(rdy8), 64'd0);
        chk("reset result8", {48'b0, res8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("u 7/2",        0, 0, 32'd7,        32'd2,        32'd3,        32'd1,        0);
        run_op("s -7/2",       0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        run_op("s 7/-2",       0, 1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        0);
        run_op("s min/-1",     0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0);
        run_op("u max/1",      0, 0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        0);
        run_op("u div0",       0, 0, 32'd1234,     32'd0,        32'd0,        32'd0,        0);
        run_op("s div0",       0, 1, 32'hFFFFFF00, 32'd0,        32'd0,        32'd0,        0);
        run_op("latched",      0, 0, 32'd100,      32'd7,        32'd14,       32'd2,        1);
        run_op("w8 u 200/7",   1, 0, 32'd200,      32'd7,        32'd28,       32'd4,        0);
        run_op("w8 s min/-1",  1, 1, 32'h80,       32'hFF,       32'h80,       32'd0,        0);
        run_op("w8 s -100/7",  1, 1, 32'h9C,       32'd7,        32'hF2,       32'hFE,       0);
        run_op("w8 div0",      1, 0, 32'd55,       32'd0,        32'd0,        32'd0,        0);

        run_abort("annul@10", 10, 0);
        run_abort("rst@5",    5,  1);

        // start and annul on the same edge in IDLE must not accept
        begin
            bit seen;
            @(negedge clk);
            a32 = 32'd9; b32 = 32'd2; st32 = 1'b1; an32 = 1'b1;
            @(negedge clk);
            st32 = 1'b0; an32 = 1'b0;
            seen = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (rdy32) seen = 1'b1;
            end
            chk("start+annul no accept", 64'(seen), 64'd0);
        end

        for (int i = 0; i < 20; i++) begin
            rsg = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            rexp = ref_div32(rsg, ra, rb);
            run_op($sformatf("rand%0d", i), 0, rsg, ra, rb, rexp[31:0], rexp[63:32], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative restoring divider for the CPU execute stage. It computes quotient and remainder of signed or unsigned WIDTH-bit operands in a fixed WIDTH+1 cycles after acceptance and needs no vendor IP. It latches its operands at acceptance, so the pipeline may stall or flush around it. It keeps the existing start/annul/ready handshake so the EX-stage stall logic is unchanged.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled only at acceptance.
- opdata1_i  in  WIDTH  dividend; sampled only at acceptance.
- opdata2_i  in  WIDTH  divisor; sampled only at acceptance.
- start_i  in  1  request; held high by EX until ready_o is seen, then dropped.
- annul_i  in  1  cancel (flush); has priority over start_i.
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; valid while ready_o=1, zero otherwise.
- ready_o  out  1  result valid; held until start_i drops.

## Operation
States are IDLE, DIVZERO, ON and END. Reset puts the block in IDLE with ready_o=0, result_o=0 and all internal registers cleared.

- IDLE:
  - start_i=1 and annul_i=0 is acceptance.
    - Divisor 0 goes to DIVZERO.
    - Any other divisor goes to ON. The block latches signed_div_i and both operand signs. It loads |dividend| and |divisor| as unsigned values (absolute value only when signed), clears the partial remainder and sets cnt=0.
  - Any other input keeps ready_o=0 and result_o=0.
- ON performs one restoring step per cycle:
  - Compute r' = {rem[WIDTH-1:0], dividend MSB}.
  - If r' ≥ divisor, then rem = r' − divisor and shift in quotient bit 1.
  - Otherwise rem = r' and shift in quotient bit 0.
  - Shift the dividend left by one and increment cnt.
  - Use a WIDTH+1-bit subtractor.
- When cnt reaches WIDTH (after the last step), the finalize cycle runs:
  - In signed mode, negate the quotient if the dividend and divisor signs differ.
  - In signed mode, negate the remainder if the dividend was negative.
  - Register result_o, set ready_o=1 and go to END.
- annul_i=1 in ON or DIVZERO returns the block to IDLE with ready_o=0 and result_o=0 on the next edge.
- DIVZERO: the next state is END with result_o=0, and ready_o=1 on entering END.
- END:
  - Holds result_o and ready_o=1 while start_i=1.
  - start_i=0 returns the block to IDLE with ready_o=0 and result_o=0.
  - annul_i is ignored in END.
- Signed most-negative ÷ −1 returns quotient = most-negative (wrap) and remainder = 0; no exception is raised.
- Input changes after acceptance have no effect on the result.

## Timing
- Let the acceptance edge be T0. ON steps occur on edges T1..TWIDTH, and the finalize edge is TWIDTH+1.
- ready_o is high after edge T0+WIDTH+1, i.e. WIDTH+1 cycles after acceptance (33 for WIDTH=32).
- Divide-by-zero: ready_o is high after edge T0+2.
- Back-to-back operations: start_i must drop for at least one cycle. The earliest re-acceptance is the edge after IDLE is re-entered.
- Same-edge start_i=1 with annul_i=1 in IDLE: no acceptance.
- rst asserted in any state goes to IDLE on that edge and overrides everything else.

## Structure
- Shared package div_pkg holds:
  - the state encodings DIV_FREE=2'b00, DIV_ON=2'b01, DIV_END=2'b10, DIV_BYZERO=2'b11, consistent with the existing divider encoding;
  - a function for the result packing order.
- One combinational sub-module, div_step (WIDTH parameter): inputs are the partial remainder, dividend MSB and divisor; outputs are the next remainder and the quotient bit.
- The counter is $clog2(WIDTH+1) bits wide.

## Test plan
- Unsigned 7 ÷ 2, WIDTH=32 → after 33 cycles ready_o=1 and result_o=0x00000001_00000003; result holds while start_i stays high; dropping start_i gives ready_o=0 and result_o=0 on the next edge.
- Signed −7 ÷ 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 ÷ −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF ÷ 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero (any dividend) → ready_o high 2 cycles after acceptance with result_o=0.
- annul_i pulsed at cycle 10 of ON → IDLE next edge and ready_o never rises. rst at cycle 5 gives the same. Change operands after acceptance and check the result uses the latched values.
- WIDTH=8 instance, unsigned 200 ÷ 7 → quotient 28 (0x1C), remainder 4, ready_o after 9 cycles. Random signed/unsigned regression against a reference model.
